freq_sweep: RTL
===============

FREQ_SWEEP -- requirements
Module: freq_sweep

Interface
REQ-001 The block SHALL have parameter PHASE_WIDTH, default 32, the width of every phase-increment word.
REQ-002 The block SHALL have parameter DWELL_WIDTH, default 16, the width of the dwell count.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port cfg_valid, input, 1, sweep configuration present.
REQ-006 The block SHALL have port cfg_ready, output, 1, block accepts a configuration.
REQ-007 The block SHALL have ports start_inc, stop_inc and step_inc, input, PHASE_WIDTH each: first increment, final increment, and magnitude of change per step.
REQ-008 The block SHALL have port dwell, input, DWELL_WIDTH, number of output transfers per step.
REQ-009 The block SHALL have port repeat, input, 1: 1 restarts the sweep at start_inc after the final step, 0 makes it one-shot.
REQ-010 The block SHALL have port abort, input, 1, synchronous request to stop sweeping.
REQ-011 The block SHALL have port out_valid, output, 1, phase_inc is valid.
REQ-012 The block SHALL have port out_ready, input, 1, downstream NCO accepts phase_inc.
REQ-013 The block SHALL have port phase_inc, output, PHASE_WIDTH, current frequency word fed to the NCO.
REQ-014 The block SHALL have port busy, output, 1, high in SWEEP.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse when a one-shot sweep completes or is aborted.

Function
REQ-016 The FSM SHALL have states IDLE, SWEEP and DONE; cfg_ready SHALL be 1 only in IDLE.
REQ-017 A configuration SHALL be captured into internal registers on cfg_valid && cfg_ready; inputs are don't-care at all other times.
REQ-018 After the capture in cycle N, the block SHALL be in SWEEP in cycle N+1 with out_valid=1 and phase_inc=start_inc.
REQ-019 A transfer occurs on out_valid && out_ready; phase_inc SHALL stay stable and out_valid SHALL stay high while out_ready=0.
REQ-020 A dwell counter SHALL count transfers; dwell=0 SHALL be treated as 1.
REQ-021 On the transfer that completes a dwell, the counter SHALL clear and phase_inc SHALL advance by step_inc in the next cycle.
REQ-022 Step arithmetic SHALL be computed at PHASE_WIDTH+1 bits; a sum beyond stop_inc, or a carry out, SHALL clamp phase_inc to stop_inc, so the increment never wraps.
REQ-023 The step at stop_inc is the final step; after it dwells, the block SHALL reload start_inc and stay in SWEEP if repeat=1, otherwise go to DONE.
REQ-024 step_inc=0, or start_inc==stop_inc, SHALL produce a single final step at start_inc.
REQ-025 DONE SHALL last one cycle with done=1 and out_valid=0, then the block SHALL return to IDLE.
REQ-026 abort in SWEEP SHALL take priority over a simultaneous transfer: the next cycle SHALL be DONE with out_valid=0; the in-flight transfer still counts downstream.
REQ-027 abort in IDLE or DONE SHALL be ignored.

Reset
REQ-028 While rst=1, the state SHALL be IDLE and out_valid, busy, done and phase_inc SHALL be 0.
REQ-029 cfg_ready SHALL be 1 during and after reset, and all captured configuration and the dwell counter SHALL be 0.
REQ-030 Reset asserted mid-sweep SHALL drop out_valid immediately, without waiting for a clock edge.

Configuration
REQ-031 With macro FREQ_SWEEP_DOWN_EN defined, start_inc > stop_inc SHALL sweep downward by step_inc, with a borrow or an undershoot clamping to stop_inc.
REQ-032 Without FREQ_SWEEP_DOWN_EN, start_inc > stop_inc SHALL produce a single final step at start_inc, and no subtractor SHALL be synthesised.

Structure
REQ-033 Package sweep_pkg SHALL hold the FSM state enum type and the default width constants for PHASE_WIDTH and DWELL_WIDTH.
REQ-034 Sub-module dwell_counter SHALL contain the transfer counter and the dwell-complete flag; the FSM and step arithmetic SHALL remain in freq_sweep.

Verification
REQ-035 The bench SHALL cover: start=100, stop=130, step=10, dwell=2, repeat=0, out_ready=1 -> phase_inc 100,100,110,110,120,120,130,130, then a one-cycle done pulse.
REQ-036 The bench SHALL cover: the same configuration with out_ready toggling 1/0 each cycle -> the identical value sequence with phase_inc held during every stall.
REQ-037 The bench SHALL cover: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=1 -> output 0xFFFFFFF0, 0xFFFFFFFF, then done, with no wrap.
REQ-038 The bench SHALL cover: repeat=1, start=5, stop=7, step=1, dwell=1 -> 5,6,7,5,6,7,... and done never pulses.
REQ-039 The bench SHALL cover: abort asserted on the 3rd transfer -> out_valid=0 on the next cycle, done pulses, and cfg_ready=1 one cycle later.
REQ-040 The bench SHALL cover: rst asserted mid-sweep -> out_valid=0 asynchronously, and start=9, stop=3, step=2 after reset -> 9,7,5,3 with FREQ_SWEEP_DOWN_EN, or a single step at 9 without it.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and default widths for the frequency sweep generator.
package sweep_pkg;

  localparam int unsigned PhaseWidthDefault = 32;
  localparam int unsigned DwellWidthDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/dwell_counter.sv
// Counts output transfers within one frequency step and flags the transfer that
// completes the dwell. A dwell of 0 behaves like a dwell of 1.
module dwell_counter
  import sweep_pkg::*;
#(
  parameter int unsigned DWELL_WIDTH = DwellWidthDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   xfer,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic                   dwell_done
);

  logic [DWELL_WIDTH-1:0] count_q;
  logic [DWELL_WIDTH-1:0] dwell_last;

  // Index of the last transfer of a step; dwell=0 collapses onto a single transfer.
  always_comb begin
    dwell_last = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
    dwell_done = xfer && (count_q == dwell_last);
  end

  // Transfer counter, cleared on a new configuration or at the end of each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (xfer) begin
      if (dwell_done) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + DWELL_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/freq_sweep.sv
// Stepped frequency sweep generator feeding phase increments to an NCO.
// Optional feature: define FREQ_SWEEP_DOWN_EN to allow downward sweeps when
// start_inc > stop_inc; without it such a configuration yields one step at start_inc.
// The repeat control is exposed as repeat_en because "repeat" is a reserved word.
module freq_sweep
  import sweep_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = PhaseWidthDefault,
  parameter int unsigned DWELL_WIDTH = DwellWidthDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] start_inc,
  input  logic [PHASE_WIDTH-1:0] stop_inc,
  input  logic [PHASE_WIDTH-1:0] step_inc,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic                   repeat_en,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic                   busy,
  output logic                   done
);

  sweep_state_e state_q;

  logic [PHASE_WIDTH-1:0] start_q;
  logic [PHASE_WIDTH-1:0] stop_q;
  logic [PHASE_WIDTH-1:0] step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   repeat_q;
  logic                   first_last_q;  // start step is already the final step
  logic                   last_q;        // current step is the final step
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef FREQ_SWEEP_DOWN_EN
  logic                   down_q;
  logic [PHASE_WIDTH:0]   diff_ext;
  logic [PHASE_WIDTH-1:0] down_next;
`endif

  logic                   capture;
  logic                   xfer;
  logic                   dwell_done;
  logic                   cfg_last;
  logic [PHASE_WIDTH:0]   sum_ext;
  logic [PHASE_WIDTH-1:0] up_next;
  logic [PHASE_WIDTH-1:0] next_phase;

  assign cfg_ready = (state_q == StIdle);
  assign capture   = cfg_valid && cfg_ready;
  assign xfer      = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign phase_inc = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;

  dwell_counter #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (capture),
    .xfer       (xfer),
    .dwell      (dwell_q),
    .dwell_done (dwell_done)
  );

  // Next step value, one bit wider so a carry or borrow clamps to stop instead of wrapping.
  always_comb begin
    sum_ext = {1'b0, phase_q} + {1'b0, step_q};
    up_next = (sum_ext[PHASE_WIDTH] || (sum_ext[PHASE_WIDTH-1:0] > stop_q)) ?
              stop_q : sum_ext[PHASE_WIDTH-1:0];
`ifdef FREQ_SWEEP_DOWN_EN
    diff_ext   = {1'b0, phase_q} - {1'b0, step_q};
    down_next  = (diff_ext[PHASE_WIDTH] || (diff_ext[PHASE_WIDTH-1:0] < stop_q)) ?
                 stop_q : diff_ext[PHASE_WIDTH-1:0];
    next_phase = down_q ? down_next : up_next;
    cfg_last   = (step_inc == '0) || (start_inc == stop_inc);
`else
    next_phase = up_next;
    cfg_last   = (step_inc == '0) || (start_inc >= stop_inc);
`endif
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      repeat_q     <= 1'b0;
      first_last_q <= 1'b0;
      last_q       <= 1'b0;
      phase_q      <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FREQ_SWEEP_DOWN_EN
      down_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (capture) begin
            start_q      <= start_inc;
            stop_q       <= stop_inc;
            step_q       <= step_inc;
            dwell_q      <= dwell;
            repeat_q     <= repeat_en;
            first_last_q <= cfg_last;
            last_q       <= cfg_last;
            phase_q      <= start_inc;
            out_valid_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StSweep;
`ifdef FREQ_SWEEP_DOWN_EN
            down_q       <= (start_inc > stop_inc);
`endif
          end
        end
        StSweep: begin
          // Abort wins over a step advance in the same cycle.
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else if (dwell_done) begin
            if (last_q) begin
              if (repeat_q) begin
                phase_q <= start_q;
                last_q  <= first_last_q;
              end else begin
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                state_q     <= StDone;
              end
            end else begin
              phase_q <= next_phase;
              last_q  <= (next_phase == stop_q);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
